// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the fabric-side masters.
//   RESP_*       : AXI RRESP/BRESP codes
//   PROT_DEFAULT : AxPROT value driven on every request
//   state_e      : command master FSM state encoding
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_A,
        ST_READ_D,
        ST_RSP
    } state_e;

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between a master and a slave.
//   master modport : drives AW/W/AR channels and BREADY/RREADY
//   slave modport  : drives AWREADY/WREADY/ARREADY and the B/R channels
interface axil_cmd_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_timeout_ctr.sv
// Transaction watchdog: counts enabled cycles since the last clear.
//   aclk, aresetn : clock, synchronous active-low reset
//   clear         : restart the count (new transaction issued)
//   enable        : transaction in flight this cycle
//   expired       : this enabled cycle is the TIMEOUT_CYCLES-th one
module axil_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != CW'(TIMEOUT_CYCLES))) begin
            count_q <= count_q + CW'(1);
        end
    end

    // Flag in the cycle whose increment lands on TIMEOUT_CYCLES, so the
    // owner can abort on that same edge.
    assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master fed by a command/response stream.
//   M_AXI_ACLK, M_AXI_ARESETN : clock, synchronous active-low reset
//   cmd_*                     : command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                     : response out (valid/ready, rdata, resp, timeout)
//   M_AXI                     : AXI4-Lite master bus
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    axil_cmd_master_if.master               M_AXI
);
    state_e                            state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic                              aw_done_q, w_done_q, b_done_q;
    logic [1:0]                        bresp_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]     rdata_q;
    logic [1:0]                        resp_q;
    logic                              timeout_q;

    logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic wr_complete, rd_complete, busy, expired;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign aw_fire  = M_AXI.AWVALID && M_AXI.AWREADY;
    assign w_fire   = M_AXI.WVALID && M_AXI.WREADY;
    assign b_fire   = M_AXI.BVALID && M_AXI.BREADY;
    assign ar_fire  = M_AXI.ARVALID && M_AXI.ARREADY;
    assign r_fire   = M_AXI.RVALID && M_AXI.RREADY;

    // Any of the three write events may be the last one; count it this cycle.
    assign wr_complete = (state_q == ST_WRITE) && (aw_done_q || aw_fire)
                         && (w_done_q || w_fire) && (b_done_q || b_fire);
    assign rd_complete = (state_q == ST_READ_D) && r_fire;
    assign busy        = (state_q == ST_WRITE) || (state_q == ST_READ_A)
                         || (state_q == ST_READ_D);

    axil_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .aclk    (M_AXI_ACLK),
        .aresetn (M_AXI_ARESETN),
        .clear   (cmd_fire),
        .enable  (busy),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_fire) state_d = cmd_write ? ST_WRITE : ST_READ_A;
            ST_WRITE:  if (wr_complete || expired) state_d = ST_RSP;
            ST_READ_A: begin
                if (expired)      state_d = ST_RSP;
                else if (ar_fire) state_d = ST_READ_D;
            end
            ST_READ_D: if (rd_complete || expired) state_d = ST_RSP;
            ST_RSP:    if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cmd_fire) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                b_done_q  <= 1'b0;
            end
            if (aw_fire) aw_done_q <= 1'b1;
            if (w_fire)  w_done_q  <= 1'b1;
            if (b_fire) begin
                b_done_q <= 1'b1;
                bresp_q  <= M_AXI.BRESP;
            end
            // Completion takes priority over a simultaneous timeout.
            if (wr_complete) begin
                rdata_q   <= '0;
                resp_q    <= b_fire ? M_AXI.BRESP : bresp_q;
                timeout_q <= 1'b0;
            end else if (rd_complete) begin
                rdata_q   <= M_AXI.RDATA;
                resp_q    <= M_AXI.RRESP;
                timeout_q <= 1'b0;
            end else if (expired) begin
                rdata_q   <= '0;
                resp_q    <= RESP_SLVERR;
                timeout_q <= 1'b1;
            end
        end
    end

    // Gated by reset so everything reads as idle while reset is held.
    assign cmd_ready   = M_AXI_ARESETN && (state_q == ST_IDLE);
    assign rsp_valid   = M_AXI_ARESETN && (state_q == ST_RSP);
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timeout_q;

    assign M_AXI.AWADDR  = addr_q;
    assign M_AXI.AWPROT  = PROT_DEFAULT;
    assign M_AXI.AWVALID = M_AXI_ARESETN && (state_q == ST_WRITE) && !aw_done_q;
    assign M_AXI.WDATA   = wdata_q;
    assign M_AXI.WSTRB   = wstrb_q;
    assign M_AXI.WVALID  = M_AXI_ARESETN && (state_q == ST_WRITE) && !w_done_q;
    assign M_AXI.BREADY  = M_AXI_ARESETN && (state_q == ST_WRITE);
    assign M_AXI.ARADDR  = addr_q;
    assign M_AXI.ARPROT  = PROT_DEFAULT;
    assign M_AXI.ARVALID = M_AXI_ARESETN && (state_q == ST_READ_A);
    assign M_AXI.RREADY  = M_AXI_ARESETN && (state_q == ST_READ_D);

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
AXI4-Lite master sitting directly upstream of the board's AXI4-Lite slave peripherals. It converts a simple command/response stream (one transaction at a time) from fabric logic into AXI4-Lite read or write bursts of length 1. It returns read data and the response code, and aborts hung transactions with a timeout. Only one transaction is outstanding at any time.

Parameters:
C_M_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_M_AXI_ADDR_WIDTH, 32, address width.
TIMEOUT_CYCLES, 256, cycles from issue to abort; must be ≥ 2; counter width $clog2(TIMEOUT_CYCLES+1).

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  synchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR  byte address
cmd_wdata  in  DATA  write data
cmd_wstrb  in  DATA/8  write strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA  read data (0 for writes/timeouts)
rsp_resp  out  2  AXI RESP/BRESP; 2'b10 on timeout
rsp_timeout  out  1  transaction aborted by timeout
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths; PROT tied 3'b000.

Behaviour:
- Reset: reset is synchronous and active-low on M_AXI_ARESETN, single clock M_AXI_ACLK. While reset is low, all *VALID, BREADY, RREADY, cmd_ready, rsp_valid and rsp_timeout are 0; rsp_rdata and rsp_resp are 0; FSM enters IDLE.
- States: IDLE, WRITE, READ_A, READ_D, RSP.
- IDLE:
  - cmd_ready=1.
  - On handshake: latch addr, wdata, wstrb; clear the timeout counter.
  - write → WRITE: AWVALID=1, WVALID=1, BREADY=1, all asserted on the next cycle.
  - read → READ_A: ARVALID=1.
- WRITE:
  - AWVALID drops the cycle after the AW handshake; WVALID drops the cycle after the W handshake. AW and W complete independently, in either order or in the same cycle.
  - BREADY is held 1 for the whole state. A B handshake is accepted in any cycle, including the same cycle as the W handshake, or before AW completes (slaves may drive BVALID combinationally from WVALID). BRESP is captured into a sticky b_done flag.
  - Exit to RSP when AW done, W done and b_done are all set. This may happen in the same cycle as the last of the three events.
- READ_A: ARVALID held until ARREADY, then → READ_D with RREADY=1. ARVALID must not depend on RREADY.
- READ_D: on RVALID, capture RDATA/RRESP → RSP. Minimum read latency, cmd handshake to rsp_valid: 3 cycles against a slave with ARREADY=1 and registered RVALID.
- RSP:
  - rsp_valid=1 with outputs stable until rsp_ready; then → IDLE.
  - cmd_ready stays 0 until IDLE; no back-to-back overlap.
- Timeout:
  - The counter increments every cycle in WRITE/READ_A/READ_D.
  - When it reaches TIMEOUT_CYCLES: drop all VALID/READY, set rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0 → RSP.
  - Dropping VALID without a handshake is a deliberate recovery action for hung slaves; upstream is expected to reset the interconnect.
  - If a completion and the timeout occur in the same cycle, completion wins (rsp_timeout=0).
- Write response: rsp_rdata=0, rsp_resp=captured BRESP.
- Reset mid-transaction: immediate return to IDLE next clock with all outputs at reset values; no response is emitted for the aborted command.

Decomposition:
- Shared package axil_pkg: RESP codes (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), FSM state encoding, PROT default 3'b000.
- One natural sub-module: axil_timeout_ctr (clear/enable/expired, parameterised by TIMEOUT_CYCLES), reusable by other masters.
- The rest is a single FSM file.

Test Plan:
1. Read against a constant slave (ARREADY=1, registered RVALID, data 32'hDCBA4321): cmd read addr 0x0 → rsp_valid 3 cycles after the cmd handshake, rsp_rdata=32'hDCBA4321, rsp_resp=00, rsp_timeout=0.
2. Write with AWREADY=WREADY=1 and BVALID=WVALID combinational: cmd write 0x4 data 0x12345678 strb 0xF → AW/W/B complete in one cycle, rsp_valid next cycle, rsp_resp=00, rsp_rdata=0.
3. Skewed write: AWREADY delayed 5 cycles, WREADY immediate, BVALID arriving with W → AWVALID held 5 cycles, response only after AW; b_done retained, no timeout.
4. Hung slave: ARREADY=0 forever, TIMEOUT_CYCLES=16 → ARVALID drops after 16 cycles, rsp_timeout=1, rsp_resp=10, rsp_rdata=0; the next command is accepted normally.
5. Response back-pressure: rsp_ready held 0 for 10 cycles → rsp_valid and data stable, cmd_ready=0 throughout; rsp_ready=1 → IDLE, cmd_ready=1 the following cycle.
6. Reset mid-write: assert M_AXI_ARESETN=0 while AWVALID=1 → next clock all VALID/READY=0, rsp_valid=0; after release, a read returns correct data.
